// File: rtl/mult_div_unit.sv
// mult_div_unit
//   Iterative radix-2 multiply / restoring divide unit, signed or unsigned.
//   A one-cycle start pulse in IDLE latches the operands. WIDTH iterations
//   follow, one per clock. A fix-up cycle then applies the sign correction and
//   loads HI/LO, and done pulses for one cycle. A divide by zero skips the
//   iterations: done and div_zero pulse together one cycle after the start, and
//   HI/LO are left unchanged.
// Ports
//   clk, reset            clock; asynchronous active-high reset
//   mult_start, div_start one-cycle start pulses (multiply wins if both are high)
//   signed_en             1 = two's-complement operands, sampled with the start
//   a_in, b_in            multiplicand/dividend, multiplier/divisor
//   busy                  high while an operation is in progress
//   done, div_zero        one-cycle completion pulse; div_zero = divisor was 0
//   hi_out, lo_out        MULT: product high/low; DIV: remainder/quotient
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mult_start,
  input  logic             div_start,
  input  logic             signed_en,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX, ZERO} state_t;

  state_t           state_reg, state_next;
  logic [CW-1:0]    count_reg;
  // acc_reg: upper product accumulator / partial remainder
  // low_reg: multiplier shifting out / quotient shifting in
  // opnd_reg: multiplicand / divisor magnitude
  logic [WIDTH-1:0] acc_reg, low_reg, opnd_reg;
  logic             is_div_reg, neg_lo_reg, neg_hi_reg;
  logic             done_reg, div_zero_reg;
  logic [WIDTH-1:0] hi_reg, lo_reg;

  // Operand magnitudes. A WIDTH-bit unsigned magnitude holds 2^(WIDTH-1),
  // so the most negative value needs no extra bit.
  logic             a_neg, b_neg, take_div;
  logic [WIDTH-1:0] a_mag, b_mag;

  assign take_div = div_start & ~mult_start;
  assign a_neg    = signed_en & a_in[WIDTH-1];
  assign b_neg    = signed_en & b_in[WIDTH-1];
  assign a_mag    = a_neg ? (~a_in + 1'b1) : a_in;
  assign b_mag    = b_neg ? (~b_in + 1'b1) : b_in;

  // Multiply step: (WIDTH+1)-bit add keeps the carry for the right shift.
  logic [WIDTH:0]   mul_sum;
  assign mul_sum = {1'b0, acc_reg} + (low_reg[0] ? {1'b0, opnd_reg} : {(WIDTH+1){1'b0}});

  // Divide step: the shifted remainder can reach WIDTH+1 bits. The trial
  // difference fits in WIDTH bits whenever no borrow occurs.
  logic [WIDTH:0]   rem_sh;
  logic             div_ge;
  logic [WIDTH-1:0] div_diff;
  assign rem_sh   = {acc_reg, low_reg[WIDTH-1]};
  assign div_ge   = rem_sh >= {1'b0, opnd_reg};
  assign div_diff = rem_sh[WIDTH-1:0] - opnd_reg;

  // Sign fix-up of the final magnitudes.
  logic [2*WIDTH-1:0] prod_mag, prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix;
  assign prod_mag = {acc_reg, low_reg};
  assign prod_fix = neg_lo_reg ? (~prod_mag + 1'b1) : prod_mag;
  assign quot_fix = neg_lo_reg ? (~low_reg + 1'b1) : low_reg;
  assign rem_fix  = neg_hi_reg ? (~acc_reg + 1'b1) : acc_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    busy       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (mult_start)                   state_next = RUN;
        else if (div_start && b_in == '0) state_next = ZERO;
        else if (div_start)               state_next = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (count_reg == CW'(1)) state_next = FIX;
      end
      FIX: begin
        busy       = 1'b1;
        state_next = IDLE;
      end
      ZERO:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_reg    <= '0;
      acc_reg      <= '0;
      low_reg      <= '0;
      opnd_reg     <= '0;
      is_div_reg   <= 1'b0;
      neg_lo_reg   <= 1'b0;
      neg_hi_reg   <= 1'b0;
      done_reg     <= 1'b0;
      div_zero_reg <= 1'b0;
      hi_reg       <= '0;
      lo_reg       <= '0;
    end else begin
      done_reg     <= 1'b0;
      div_zero_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (state_next == RUN) begin
            count_reg  <= CW'(WIDTH);
            is_div_reg <= take_div;
            acc_reg    <= '0;
            low_reg    <= take_div ? a_mag : b_mag;
            opnd_reg   <= take_div ? b_mag : a_mag;
            neg_lo_reg <= a_neg ^ b_neg;
            neg_hi_reg <= take_div & a_neg;  // remainder follows the dividend
          end
        end
        RUN: begin
          count_reg <= count_reg - 1'b1;
          if (is_div_reg) begin
            acc_reg <= div_ge ? div_diff : rem_sh[WIDTH-1:0];
            low_reg <= {low_reg[WIDTH-2:0], div_ge};
          end else begin
            acc_reg <= mul_sum[WIDTH:1];
            low_reg <= {mul_sum[0], low_reg[WIDTH-1:1]};
          end
        end
        FIX: begin
          done_reg <= 1'b1;
          if (is_div_reg) begin
            hi_reg <= rem_fix;
            lo_reg <= quot_fix;
          end else begin
            hi_reg <= prod_fix[2*WIDTH-1:WIDTH];
            lo_reg <= prod_fix[WIDTH-1:0];
          end
        end
        ZERO: begin
          done_reg     <= 1'b1;
          div_zero_reg <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign done     = done_reg;
  assign div_zero = div_zero_reg;
  assign hi_out   = hi_reg;
  assign lo_out   = lo_reg;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit
//   Self-checking bench for mult_div_unit at WIDTH = 32. Directed vectors and
//   randomized operations are compared against a reference model that uses
//   plain 64-bit arithmetic.
module tb_mult_div_unit;

  localparam int W = 32;

  logic         clk, reset;
  logic         mult_start, div_start, signed_en;
  logic [W-1:0] a_in, b_in;
  logic         busy, done, div_zero;
  logic [W-1:0] hi_out, lo_out;

  int checks = 0;
  int errors = 0;

  // Model of the HI/LO registers (held across a divide by zero).
  logic [W-1:0] exp_hi = '0, exp_lo = '0;

  mult_div_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .mult_start(mult_start), .div_start(div_start),
    .signed_en(signed_en), .a_in(a_in), .b_in(b_in), .busy(busy), .done(done),
    .div_zero(div_zero), .hi_out(hi_out), .lo_out(lo_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: full-width arithmetic on the operand values.
  function automatic void ref_op(input logic d, input logic s, input logic [W-1:0] a,
                                 input logic [W-1:0] b, output logic dz);
    longint sa, sb;
    logic [63:0] p;
    dz = 1'b0;
    sa = s ? longint'($signed(a)) : longint'({32'b0, a});
    sb = s ? longint'($signed(b)) : longint'({32'b0, b});
    if (!d) begin
      p = 64'(sa * sb);
      exp_hi = p[63:32];
      exp_lo = p[31:0];
    end else if (b == '0) begin
      dz = 1'b1;
    end else begin
      p = 64'(sa / sb);
      exp_lo = p[31:0];
      p = 64'(sa % sb);
      exp_hi = p[31:0];
    end
  endfunction

  // Drives one start pulse and waits (bounded) for done.
  // lat = edges after the start-sampling edge until done is seen (0 = timeout).
  task automatic do_op(input logic m, input logic d, input logic s,
                       input logic [W-1:0] a, input logic [W-1:0] b,
                       output int lat, output int busy_cnt,
                       output logic [W-1:0] hi, output logic [W-1:0] lo, output logic dz);
    lat = 0; busy_cnt = 0; hi = 'x; lo = 'x; dz = 1'bx;
    @(negedge clk);
    mult_start = m; div_start = d; signed_en = s; a_in = a; b_in = b;
    @(posedge clk); #1;
    mult_start = 1'b0; div_start = 1'b0;
    a_in = $urandom; b_in = $urandom; signed_en = 1'($urandom);
    if (busy) busy_cnt++;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = i; hi = hi_out; lo = lo_out; dz = div_zero;
        break;
      end
      if (busy) busy_cnt++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; mult_start = 0; div_start = 0; signed_en = 0; a_in = '0; b_in = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, div_zero} !== 3'b000 || hi_out !== '0 || lo_out !== '0) begin
      errors++;
      $display("FAIL reset_state: busy/done/dz=%b%b%b hi=%h lo=%h, required 000 0 0",
               busy, done, div_zero, hi_out, lo_out);
    end
    @(negedge clk) reset = 1'b0;
    $display("reset: outputs hi=%h lo=%h", hi_out, lo_out);
  endtask

  // Spec vectors plus latency and busy-window checks.
  task automatic test_directed;
    logic [W-1:0] va [6], vb [6], hi, lo;
    logic vd [6], vs [6], dz, edz;
    int lat, bc;
    va = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd7, 32'hFFFF_FFF9, 32'h8000_0000, 32'h8000_0000};
    vb = '{32'd7, 32'd2, 32'hFFFF_FFFE, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    vd = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    vs = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 6; i++) begin
      do_op(~vd[i], vd[i], vs[i], va[i], vb[i], lat, bc, hi, lo, dz);
      ref_op(vd[i], vs[i], va[i], vb[i], edz);
      $display("directed %0d: div=%b sgn=%b a=%h b=%h -> hi=%h lo=%h lat=%0d busy=%0d",
               i, vd[i], vs[i], va[i], vb[i], hi, lo, lat, bc);
      checks++;
      if (hi !== exp_hi || lo !== exp_lo || dz !== edz) begin
        errors++;
        $display("FAIL directed_result %0d: hi=%h lo=%h dz=%b, required hi=%h lo=%h dz=%b",
                 i, hi, lo, dz, exp_hi, exp_lo, edz);
      end
      checks++;
      if (lat != W + 1 || bc != W + 1) begin
        errors++;
        $display("FAIL directed_timing %0d: latency=%0d busy_cycles=%0d, required %0d %0d",
                 i, lat, bc, W + 1, W + 1);
      end
    end
    // done and div_zero must be single-cycle pulses
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL done_pulse: done=%b busy=%b one cycle later, required 0 0", done, busy);
    end
  endtask

  task automatic test_div_zero;
    logic [W-1:0] hi, lo;
    logic dz, edz;
    int lat, bc;
    do_op(1'b1, 1'b0, 1'b0, 32'h1234_5678, 32'h9ABC_DEF1, lat, bc, hi, lo, dz);
    ref_op(1'b0, 1'b0, 32'h1234_5678, 32'h9ABC_DEF1, edz);
    do_op(1'b0, 1'b1, 1'b1, 32'd99, 32'd0, lat, bc, hi, lo, dz);
    ref_op(1'b1, 1'b1, 32'd99, 32'd0, edz);
    $display("div_zero: hi=%h lo=%h dz=%b lat=%0d busy=%0d", hi, lo, dz, lat, bc);
    checks++;
    if (dz !== 1'b1 || lat != 1 || bc != 0) begin
      errors++;
      $display("FAIL div_zero_flag: dz=%b latency=%0d busy_cycles=%0d, required 1 1 0", dz, lat, bc);
    end
    checks++;
    if (hi !== exp_hi || lo !== exp_lo) begin
      errors++;
      $display("FAIL div_zero_hold: hi=%h lo=%h, required hi=%h lo=%h", hi, lo, exp_hi, exp_lo);
    end
    @(posedge clk); #1;
    checks++;
    if (div_zero !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL div_zero_pulse: dz=%b done=%b next cycle, required 0 0", div_zero, done);
    end
  endtask

  task automatic test_simultaneous;
    logic [W-1:0] hi, lo;
    logic dz;
    int lat, bc;
    do_op(1'b1, 1'b1, 1'b0, 32'd6, 32'd3, lat, bc, hi, lo, dz);
    exp_hi = 32'd0; exp_lo = 32'd18;
    $display("simultaneous: hi=%h lo=%h lat=%0d", hi, lo, lat);
    checks++;
    if (hi !== exp_hi || lo !== exp_lo || dz !== 1'b0) begin
      errors++;
      $display("FAIL simultaneous: hi=%h lo=%h dz=%b, required hi=0 lo=18 dz=0", hi, lo, dz);
    end
  endtask

  // div_start and mult_start pulses during RUN must be ignored.
  task automatic test_ignore_mid_run;
    logic edz;
    int lat;
    lat = 0;
    @(negedge clk);
    mult_start = 1'b1; signed_en = 1'b1; a_in = 32'hFFFF_FF00; b_in = 32'd1000;
    @(negedge clk);
    mult_start = 1'b0;
    repeat (5) @(negedge clk);
    div_start = 1'b1; a_in = 32'd5; b_in = 32'd0;
    @(negedge clk);
    div_start = 1'b0; mult_start = 1'b1;
    @(negedge clk);
    mult_start = 1'b0;
    ref_op(1'b0, 1'b1, 32'hFFFF_FF00, 32'd1000, edz);
    for (int i = 8; i <= 100; i++) begin
      @(posedge clk); #1;
      if (done) begin lat = i; break; end
    end
    $display("ignore_mid_run: hi=%h lo=%h dz=%b lat=%0d", hi_out, lo_out, div_zero, lat);
    checks++;
    if (lat != W + 1 || hi_out !== exp_hi || lo_out !== exp_lo || div_zero !== 1'b0) begin
      errors++;
      $display("FAIL ignore_mid_run: lat=%0d hi=%h lo=%h dz=%b, required lat=%0d hi=%h lo=%h dz=0",
               lat, hi_out, lo_out, div_zero, W + 1, exp_hi, exp_lo);
    end
    // the stray start seen during RUN must not have queued another operation
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL no_queue: busy=%b after done, required 0", busy);
    end
  endtask

  task automatic test_random;
    logic [W-1:0] a, b, hi, lo;
    logic m, s, dz, edz;
    int lat, bc, sel;
    for (int n = 0; n < 40; n++) begin
      m = 1'($urandom); s = 1'($urandom);
      a = $urandom; b = $urandom;
      sel = int'($urandom_range(0, 9));
      if (sel == 0) b = '0;
      else if (sel == 1) b = 32'($urandom_range(1, 9));
      else if (sel == 2) a = 32'h8000_0000;
      else if (sel == 3) b = 32'hFFFF_FFFF;
      do_op(m, ~m, s, a, b, lat, bc, hi, lo, dz);
      ref_op(~m, s, a, b, edz);
      $display("random %0d: %s sgn=%b a=%h b=%h -> hi=%h lo=%h dz=%b lat=%0d",
               n, m ? "mul" : "div", s, a, b, hi, lo, dz, lat);
      checks++;
      if (hi !== exp_hi || lo !== exp_lo || dz !== edz || lat != (edz ? 1 : W + 1)) begin
        errors++;
        $display("FAIL random %0d: hi=%h lo=%h dz=%b lat=%0d, required hi=%h lo=%h dz=%b lat=%0d",
                 n, hi, lo, dz, lat, exp_hi, exp_lo, edz, edz ? 1 : W + 1);
      end
    end
  endtask

  // Start issued in the cycle where done is high.
  task automatic test_back_to_back;
    logic edz;
    int lat;
    lat = 0;
    @(negedge clk);
    div_start = 1'b1; signed_en = 1'b0; a_in = 32'd1000; b_in = 32'd7;
    @(negedge clk);
    div_start = 1'b0;
    for (int i = 1; i <= 100; i++) begin
      if (done) break;
      @(negedge clk);
    end
    ref_op(1'b1, 1'b0, 32'd1000, 32'd7, edz);
    checks++;
    if (done !== 1'b1 || hi_out !== exp_hi || lo_out !== exp_lo) begin
      errors++;
      $display("FAIL b2b_first: done=%b hi=%h lo=%h, required 1 %h %h", done, hi_out, lo_out, exp_hi, exp_lo);
    end
    mult_start = 1'b1; signed_en = 1'b1; a_in = 32'hFFFF_FFFB; b_in = 32'hFFFF_FFF6;
    @(posedge clk); #1;
    mult_start = 1'b0;
    ref_op(1'b0, 1'b1, 32'hFFFF_FFFB, 32'hFFFF_FFF6, edz);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_accept: busy=%b after start on done cycle, required 1", busy);
    end
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk); #1;
      if (done) begin lat = i; break; end
    end
    $display("back_to_back: hi=%h lo=%h lat=%0d", hi_out, lo_out, lat);
    checks++;
    if (lat != W + 1 || hi_out !== exp_hi || lo_out !== exp_lo) begin
      errors++;
      $display("FAIL b2b_second: lat=%0d hi=%h lo=%h, required %0d %h %h", lat, hi_out, lo_out, W + 1, exp_hi, exp_lo);
    end
  endtask

  task automatic test_async_reset;
    logic [W-1:0] hi, lo;
    logic dz, edz;
    int lat, bc;
    @(negedge clk);
    mult_start = 1'b1; signed_en = 1'b0; a_in = 32'd12345; b_in = 32'd678;
    @(posedge clk); #1;
    mult_start = 1'b0;
    repeat (10) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({busy, done, div_zero} !== 3'b000 || hi_out !== '0 || lo_out !== '0) begin
      errors++;
      $display("FAIL async_reset: busy/done/dz=%b%b%b hi=%h lo=%h before clock edge, required all 0",
               busy, done, div_zero, hi_out, lo_out);
    end
    exp_hi = '0; exp_lo = '0;
    @(negedge clk) reset = 1'b0;
    do_op(1'b0, 1'b1, 1'b1, 32'hFFFF_FF9C, 32'd7, lat, bc, hi, lo, dz);
    ref_op(1'b1, 1'b1, 32'hFFFF_FF9C, 32'd7, edz);
    $display("after_reset: hi=%h lo=%h lat=%0d busy=%0d", hi, lo, lat, bc);
    checks++;
    if (lat != W + 1 || bc != W + 1 || hi !== exp_hi || lo !== exp_lo || dz !== edz) begin
      errors++;
      $display("FAIL after_reset: lat=%0d busy=%0d hi=%h lo=%h, required %0d %0d %h %h",
               lat, bc, hi, lo, W + 1, W + 1, exp_hi, exp_lo);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_div_zero();
    test_simultaneous();
    test_ignore_mid_run();
    test_random();
    test_back_to_back();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
